// File: rtl/serial_cpu_pkg.sv
// serial_cpu_pkg: shared op codes, sequencer state encoding and default width for the serial CPU
package serial_cpu_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLLI = 3'b101;
  localparam logic [2:0] ALU_SRLI = 3'b110;
  localparam logic [2:0] ALU_NONE = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_RESP} seq_state_t;
endpackage

// File: rtl/serial_shift_sel.sv
// serial_shift_sel: picks the operand-A bit fed to the ALU on serial cycle cnt
//   a     : latched operand A
//   cnt   : current serial bit index
//   shamt : shift amount (SLLI/SRLI only)
//   op    : latched op code
//   bit_o : selected rs1 bit, zero-filled where a shift runs off the word
module serial_shift_sel import serial_cpu_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  cnt,
  input  logic [SHW-1:0]  shamt,
  input  logic [2:0]      op,
  output logic            bit_o
);
  logic [SHW:0]   up;
  logic [SHW-1:0] dn;
  // right-shift source index is one bit wider so it cannot wrap back into the word
  assign up = {1'b0, cnt} + {1'b0, shamt};
  assign dn = cnt - shamt;
  always_comb
    bit_o = op == ALU_SLLI ? (cnt >= shamt && a[dn]) :
            op == ALU_SRLI ? (up < (SHW+1)'(XLEN) && a[up[SHW-1:0]]) :
            a[cnt];
endmodule

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: streams one parallel op LSB-first through a 1-bit ALU and reassembles the result
//   req_*     : valid/ready request port (op, A, B, shamt)
//   alu_*     : serial drive to / registered result from the 1-bit ALU
//   rsp_*     : valid/ready response port carrying the assembled word
//   busy      : sequencer not idle
module serial_alu_seq import serial_cpu_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [SHW-1:0]  req_shamt,
  output logic            alu_en,
  output logic            alu_start,
  output logic [2:0]      alu_op,
  output logic            alu_rs1,
  output logic            alu_rs2,
  input  logic            alu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);
  seq_state_t      state, state_nx;
  logic [SHW-1:0]  cnt, sh_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic            run, last, pick;
  assign run  = state == S_RUN;
  assign last = cnt == SHW'(XLEN-1);
  serial_shift_sel #(.XLEN(XLEN)) u_sel (
    .a(a_q), .cnt(cnt), .shamt(sh_q), .op(op_q), .bit_o(pick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == S_IDLE  ? (req_valid ? S_RUN : S_IDLE) :
               state == S_RUN   ? (last ? S_DRAIN : S_RUN) :
               state == S_DRAIN ? S_RESP :
               (rsp_ready ? S_IDLE : S_RESP);
  // the ALU result lags one cycle, so capture starts at cnt==1 and DRAIN takes the last bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      sh_q     <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        cnt  <= '0;
        sh_q <= req_shamt;
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
      end
      if (run) cnt <= cnt + 1'b1;
      if ((run && cnt != '0) || state == S_DRAIN) result_q <= {alu_result, result_q[XLEN-1:1]};
    end
  // req_ready is held low while reset is asserted so nothing is offered mid-reset
  assign req_ready = state == S_IDLE && rst_n;
  assign busy      = state != S_IDLE;
  assign alu_en    = run;
  assign alu_start = run && cnt == '0;
  assign alu_op    = run ? op_q : '0;
  assign alu_rs1   = run && pick;
  assign alu_rs2   = run && b_q[cnt];
  assign rsp_valid = state == S_RESP;
  assign rsp_data  = result_q;
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed-vector bench for serial_alu_seq driving a behavioural 1-bit ALU
module tb_serial_alu_seq;
  import serial_cpu_pkg::*;
  localparam int XLEN = 32;
  localparam int SHW  = 5;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_op = '0;
  logic [XLEN-1:0] req_a = '0;
  logic [XLEN-1:0] req_b = '0;
  logic [SHW-1:0]  req_shamt = '0;
  logic            alu_en, alu_start, alu_rs1, alu_rs2;
  logic [2:0]      alu_op;
  logic            alu_result;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_data;
  logic            busy;
  int              n_chk = 0;
  int              n_fail = 0;
  always #5 clk = ~clk;
  serial_alu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .alu_en(alu_en), .alu_start(alu_start), .alu_op(alu_op),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );
  // behavioural 1-bit ALU: registered result, carry cleared whenever idle
  logic carry, bb, cin, s;
  always_comb begin
    bb  = alu_op == ALU_SUB ? ~alu_rs2 : alu_rs2;
    cin = (alu_op == ALU_SUB && alu_start) || carry;
    s   = alu_rs1 ^ bb ^ cin;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_result <= 1'b0;
      carry      <= 1'b0;
    end else if (!alu_en) begin
      carry <= 1'b0;
    end else begin
      carry      <= (alu_rs1 & bb) | (alu_rs1 & cin) | (bb & cin);
      alu_result <= (alu_op == ALU_ADD || alu_op == ALU_SUB) ? s :
                    alu_op == ALU_XOR ? alu_rs1 ^ alu_rs2 :
                    alu_op == ALU_AND ? alu_rs1 & alu_rs2 :
                    alu_op == ALU_OR  ? alu_rs1 | alu_rs2 :
                    (alu_op == ALU_SLLI || alu_op == ALU_SRLI) ? alu_rs1 : 1'b0;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] exp, input string tag);
    int edges;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_shamt = sh;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check({tag, "_first"}, {29'b0, alu_en, alu_start, busy}, 32'd7);
    edges = 0;
    while (!rsp_valid && edges < 4 * XLEN) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_lat"}, 32'(edges), 32'(XLEN + 1));
    check({tag, "_data"}, rsp_data, exp);
  endtask
  task automatic ack(input string tag);
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_ack"}, {30'b0, rsp_valid, busy}, 32'd0);
  endtask
  initial begin
    logic [31:0] held;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {24'b0, alu_en, alu_start, alu_op, alu_rs1, alu_rs2, rsp_valid, busy}, 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_rdy_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rdy", 32'(req_ready), 32'd1);
    do_op(ALU_ADD, 32'd5, 32'd7, 5'd0, 32'h0000000C, "add");
    ack("add");
    do_op(ALU_SUB, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE, "sub");
    ack("sub");
    do_op(ALU_ADD, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h00000000, "add_wrap");
    ack("add_wrap");
    do_op(ALU_SLLI, 32'd1, 32'hDEADBEEF, 5'd4, 32'h00000010, "slli4");
    ack("slli4");
    do_op(ALU_SRLI, 32'h80000000, 32'd0, 5'd31, 32'h00000001, "srli31");
    ack("srli31");
    do_op(ALU_SLLI, 32'h12345678, 32'd0, 5'd0, 32'h12345678, "slli0");
    ack("slli0");
    do_op(ALU_SRLI, 32'h12345678, 32'd0, 5'd8, 32'h00123456, "srli8");
    ack("srli8");
    do_op(ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, "and");
    ack("and");
    do_op(ALU_OR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, "or");
    ack("or");
    do_op(ALU_NONE, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000, "none");
    ack("none");
    do_op(ALU_ADD, 32'd10, 32'd20, 5'd7, 32'd30, "add_sh");
    ack("add_sh");
    do_op(ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, "xor_hold");
    held = rsp_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        req_valid = 1'b1;
        req_op    = ALU_ADD;
        req_a     = 32'd1;
        req_b     = 32'd1;
      end
      @(posedge clk);
      #1;
      check($sformatf("hold_data%0d", i), rsp_data, held);
      check($sformatf("hold_ctl%0d", i), {29'b0, req_ready, alu_en, rsp_valid}, 32'd1);
    end
    ack("xor_hold");
    @(negedge clk);
    check("ignored_req", {30'b0, busy, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = ALU_ADD;
    req_a     = 32'h0000FFFF;
    req_b     = 32'h00000001;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {23'b0, req_ready, alu_en, alu_start, alu_op, alu_rs1, alu_rs2, rsp_valid, busy}, 32'd0);
    check("midrst_data", rsp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(ALU_ADD, 32'h0000FFFF, 32'h00000001, 5'd0, 32'h00010000, "add_post_rst");
    ack("add_post_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
